// File: rtl/s2p_pkg.sv
// -----------------------------------------------------------------------------
// s2p_pkg
// Shared definitions for the serial-to-parallel deserializer.
//   S2P_DATA_W_DEFAULT : default word width in bits
//   cnt_w(w)           : width of a counter that indexes the bits of a w-bit word
// -----------------------------------------------------------------------------
package s2p_pkg;

  localparam int S2P_DATA_W_DEFAULT = 32'sd64;

  // Bit-counter width for a w-bit word; w is at least 2, so the result is >= 1.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/s2p_bit_counter.sv
// -----------------------------------------------------------------------------
// s2p_bit_counter
// Modulo-DATA_W bit counter with synchronous clear.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset (count -> 0)
//   inc    in  1  advance the count by one (wraps from DATA_W-1 to 0)
//   clr    in  1  force the count to 0; has priority over inc
//   last   out 1  high while count == DATA_W-1
// -----------------------------------------------------------------------------
module s2p_bit_counter
  import s2p_pkg::*;
#(
  parameter int DATA_W = S2P_DATA_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic last
);

  localparam int            CW      = cnt_w(DATA_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-count logic: clear wins, otherwise wrap at the last bit of the word.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_MAX);

endmodule

// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
// Deserializer: shifts one bit per clock from serial_in while enable is high
// and, after DATA_W bits, presents the assembled word on data_out together
// with a one-cycle data_valid strobe.
// Parameters:
//   DATA_W     word width (2..1024)
//   MSB_FIRST  1: first received bit ends in data_out[DATA_W-1]; 0: in data_out[0]
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   serial_in  in  1       serial bit, sampled while enable=1
//   enable     in  1       1: capture this cycle; 0: idle, partial word dropped
//   data_out   out DATA_W  last completed word (registered, holds)
//   data_valid out 1       one-cycle pulse when data_out takes a new word
// -----------------------------------------------------------------------------
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_W    = S2P_DATA_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              enable,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic              valid_q;
  logic              valid_d;
  logic              last_s;

  // Dropping enable clears the count so the next word restarts at bit 0.
  s2p_bit_counter #(
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enable),
    .clr   (~enable),
    .last  (last_s)
  );

  // Shift-register next state; holds (ignoring serial_in) while idle.
  always_comb begin
    shift_d = shift_q;
    if (enable) begin
      if (MSB_FIRST) begin
        shift_d = {shift_q[DATA_W-2:0], serial_in};
      end else begin
        shift_d = {serial_in, shift_q[DATA_W-1:1]};
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // Output capture: the completed word includes the bit shifted in this cycle.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (enable && last_s) begin
      data_out_d = shift_d;
      valid_d    = 1'b1;
    end else begin
      data_out_d = data_out_q;
      valid_d    = 1'b0;
    end
  end

  // Shift, output and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
`timescale 1ns/1ps
module tb_serial_to_parallel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser64, en64;
  logic [63:0] dout64;
  logic        val64;
  logic        ser8, en8;
  logic [7:0]  dout8;
  logic        val8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_to_parallel #(.DATA_W(64), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(ser64), .enable(en64),
    .data_out(dout64), .data_valid(val64)
  );

  serial_to_parallel #(.DATA_W(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser8), .enable(en8),
    .data_out(dout8), .data_valid(val8)
  );

  // Drive one cycle on the 64-bit instance, return 1 time unit after the edge.
  task automatic step64(input logic en, input logic b);
    en64 = en; ser64 = b;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic en, input logic b);
    en8 = en; ser8 = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en64 = 1'b1; ser64 = 1'bx; en8 = 1'b1; ser8 = 1'bx;
    #2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({dout64, val64, dout8, val8} !== 74'h0)
        $display("FAIL reset_hold cyc %0d: dout64=%h val64=%b dout8=%h val8=%b expected all 0", i, dout64, val64, dout8, val8);
      else n_pass++;
    end
    en64 = 1'b0; ser64 = 1'b0; en8 = 1'b0; ser8 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step64(1'b0, 1'b0);
      n_checks++;
      if ({dout64, val64} !== 65'h0)
        $display("FAIL idle_after_reset cyc %0d: dout64=%h val64=%b expected 0", i, dout64, val64);
      else n_pass++;
    end
  endtask

  task automatic test_all_ones();
    int pulses = 0; int edge_at = 0; logic [63:0] cap = '0;
    for (int i = 1; i <= 65; i++) begin
      step64(1'b1, 1'b1);
      if (val64 === 1'b1) begin pulses++; edge_at = i; cap = dout64; end
    end
    step64(1'b0, 1'b0);
    n_checks++;
    if (pulses != 1) $display("FAIL ones_pulse_count: got %0d expected 1", pulses); else n_pass++;
    n_checks++;
    if (edge_at != 64) $display("FAIL ones_pulse_edge: got %0d expected 64", edge_at); else n_pass++;
    n_checks++;
    if (cap !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL ones_data: got %h expected ffffffffffffffff", cap); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] words [2];
    int pulses = 0; int edges [4]; logic [63:0] caps [4];
    words[0] = 64'hDEAD_BEEF_0123_4567;
    words[1] = 64'h0000_0000_0000_0000;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 64; k++) begin
        step64(1'b1, words[w][63-k]);
        if (val64 === 1'b1) begin
          if (pulses < 4) begin edges[pulses] = w*64 + k + 1; caps[pulses] = dout64; end
          pulses++;
        end
      end
    end
    step64(1'b0, 1'b0);
    n_checks++;
    if (pulses != 2) $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); else n_pass++;
    if (pulses >= 2) begin
      n_checks++;
      if (edges[0] != 64) $display("FAIL b2b_edge0: got %0d expected 64", edges[0]); else n_pass++;
      n_checks++;
      if (caps[0] !== 64'hDEAD_BEEF_0123_4567) $display("FAIL b2b_data0: got %h expected deadbeef01234567", caps[0]); else n_pass++;
      n_checks++;
      if (edges[1] != 128) $display("FAIL b2b_edge1: got %0d expected 128", edges[1]); else n_pass++;
      n_checks++;
      if (caps[1] !== 64'h0) $display("FAIL b2b_data1: got %h expected 0", caps[1]); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [63:0] pat = 64'hA5A5_A5A5_A5A5_A5A5;
    int pulses = 0; int edge_at = 0; logic [63:0] cap = '0;
    for (int i = 1; i <= 20; i++) begin
      step64(1'b1, 1'b1);
      if (val64 === 1'b1) begin pulses++; edge_at = i; end
    end
    for (int i = 21; i <= 23; i++) begin
      step64(1'b0, 1'bx);
      if (val64 === 1'b1) begin pulses++; edge_at = i; end
    end
    n_checks++;
    if (pulses != 0) $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses); else n_pass++;
    for (int k = 0; k < 64; k++) begin
      step64(1'b1, pat[63-k]);
      if (val64 === 1'b1) begin pulses++; edge_at = 24 + k; cap = dout64; end
    end
    n_checks++;
    if (pulses != 1) $display("FAIL abort_pulse_count: got %0d expected 1", pulses); else n_pass++;
    n_checks++;
    if (edge_at != 87) $display("FAIL abort_pulse_edge: got %0d expected 87", edge_at); else n_pass++;
    n_checks++;
    if (cap !== pat) $display("FAIL abort_data: got %h expected %h", cap, pat); else n_pass++;
    // Enable dropped right after the word: the word must stay put.
    for (int i = 0; i < 3; i++) begin
      step64(1'b0, 1'bx);
      n_checks++;
      if (dout64 !== pat || val64 !== 1'b0)
        $display("FAIL hold_after_word cyc %0d: dout64=%h val64=%b expected %h/0", i, dout64, val64, pat);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step64(1'b1, 1'b1);
      if (val64 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL midrst_pre_pulse: got %0d expected 0", pulses); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout64, val64} !== 65'h0)
      $display("FAIL midrst_immediate: dout64=%h val64=%b expected 0", dout64, val64);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 63; i++) begin
      step64(1'b1, 1'b1);
      if (val64 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || dout64 !== 64'h0)
      $display("FAIL midrst_need_full_word: pulses=%0d dout64=%h expected 0/0", pulses, dout64);
    else n_pass++;
    step64(1'b1, 1'b1);
    n_checks++;
    if (val64 !== 1'b1 || dout64 !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL midrst_word: val64=%b dout64=%h expected 1/ffffffffffffffff", val64, dout64);
    else n_pass++;
    step64(1'b0, 1'b0);
    n_checks++;
    if (val64 !== 1'b0) $display("FAIL midrst_single_pulse: val64=%b expected 0", val64); else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    int pulses = 0; int edges [4]; logic [7:0] caps [4];
    words[0] = 8'h01;
    words[1] = 8'hB4;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        step8(1'b1, words[w][k]);
        if (val8 === 1'b1) begin
          if (pulses < 4) begin edges[pulses] = w*8 + k + 1; caps[pulses] = dout8; end
          pulses++;
        end
      end
    end
    step8(1'b0, 1'b0);
    n_checks++;
    if (pulses != 2) $display("FAIL lsb_pulse_count: got %0d expected 2", pulses); else n_pass++;
    if (pulses >= 2) begin
      n_checks++;
      if (edges[0] != 8 || caps[0] !== 8'h01)
        $display("FAIL lsb_word0: edge=%0d data=%h expected 8/01", edges[0], caps[0]);
      else n_pass++;
      n_checks++;
      if (edges[1] != 16 || caps[1] !== 8'hB4)
        $display("FAIL lsb_word1: edge=%0d data=%h expected 16/b4", edges[1], caps[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    test_lsb_first();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
